mem_dp_be: RTL

Parametrised successor to the team's generic dual-port memory: one write port with per-lane byte enables, one read port with an explicit enable, a valid strobe, selectable read latency (1 or 2) and a selectable read-during-write mode. A built-in clear sequencer fills the array with a constant after reset or on request and reports `busy_o` while it runs. Used as the backing store for endpoint buffers and descriptor tables, which must start from a known state.

---
 rtl/mem_dp_be.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_dp_be.sv
// mem_dp_be: single-clock dual-port memory with per-lane byte enables on the
// write port, an enabled read port with a valid strobe, selectable read latency
// (1 or 2) and read-during-write behaviour, plus a clear sequencer that fills
// the array with CLEAR_VALUE after reset or on request.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   wEn_i       write request (honoured only while idle)
//   wAddr_i     write address
//   wBe_i       per-lane write enables, bit k -> wData_i[k*BYTE_WID +: BYTE_WID]
//   wData_i     write data
//   rEn_i       read request (honoured only while idle)
//   rAddr_i     read address
//   rData_o     read data, held between reads
//   rValid_o    one-cycle strobe per accepted read
//   clearReq_i  start a clear (ignored while a clear is running)
//   busy_o      clear in progress
module mem_dp_be #(
  parameter int unsigned           DEPTH          = 512,
  parameter int unsigned           DATA_WID       = 8,
  parameter int unsigned           BYTE_WID       = 8,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter int unsigned           RDW_MODE       = 0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WID-1:0]   CLEAR_VALUE    = '0,
  localparam int unsigned          ADDR_WID       = $clog2(DEPTH),
  localparam int unsigned          LANES          = DATA_WID / BYTE_WID
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wEn_i,
  input  logic [ADDR_WID-1:0] wAddr_i,
  input  logic [LANES-1:0]    wBe_i,
  input  logic [DATA_WID-1:0] wData_i,
  input  logic                rEn_i,
  input  logic [ADDR_WID-1:0] rAddr_i,
  output logic [DATA_WID-1:0] rData_o,
  output logic                rValid_o,
  input  logic                clearReq_i,
  output logic                busy_o
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [ADDR_WID-1:0] LastAddr = ADDR_WID'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_WID-1:0] cnt_q, cnt_d;

  logic [DATA_WID-1:0] mem_q [DEPTH];

  logic                wr_in_range, rd_in_range;
  logic                user_we, rd_accept;
  logic                mem_we;
  logic [ADDR_WID-1:0] mem_waddr;
  logic [LANES-1:0]    mem_wbe;
  logic [DATA_WID-1:0] mem_wdata;
  logic [DATA_WID-1:0] rd_word;

  logic [DATA_WID-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic                vld1_q, vld1_d, vld2_q, vld2_d;

  // Only reachable when DEPTH is not a power of two.
  assign wr_in_range = 32'(wAddr_i) < DEPTH;
  assign rd_in_range = 32'(rAddr_i) < DEPTH;

  // Clear sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clearReq_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WID'(1);
        end
      end
    endcase
  end

  // Write port mux: the clear sequencer owns the array while running.
  always_comb begin
    user_we   = (state_q == StIdle) && wEn_i && wr_in_range;
    mem_we    = user_we;
    mem_waddr = wAddr_i;
    mem_wbe   = wBe_i;
    mem_wdata = wData_i;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wbe   = '1;
      mem_wdata = CLEAR_VALUE;
    end
    // The reset edge itself leaves the array alone.
    if (rst_i) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (mem_wbe[k]) begin
          mem_q[mem_waddr][k*BYTE_WID +: BYTE_WID] <= mem_wdata[k*BYTE_WID +: BYTE_WID];
        end
      end
    end
  end

  // Read sampling, with optional forwarding of same-edge write lanes.
  always_comb begin
    rd_accept = (state_q == StIdle) && rEn_i;
    rd_word   = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rAddr_i];
      if ((RDW_MODE == 1) && user_we && (wAddr_i == rAddr_i)) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          if (wBe_i[k]) begin
            rd_word[k*BYTE_WID +: BYTE_WID] = wData_i[k*BYTE_WID +: BYTE_WID];
          end
        end
      end
    end
  end

  // Read pipeline; data registers only load with their valid so outputs hold.
  always_comb begin
    vld1_d = rd_accept;
    rd1_d  = rd_accept ? rd_word : rd1_q;
    vld2_d = vld1_q;
    rd2_d  = vld1_q ? rd1_q : rd2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q   <= '0;
      rd1_q   <= '0;
      vld1_q  <= 1'b0;
      rd2_q   <= '0;
      vld2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      vld1_q  <= vld1_d;
      rd2_q   <= rd2_d;
      vld2_q  <= vld2_d;
    end
  end

  assign rData_o  = (READ_LATENCY == 2) ? rd2_q : rd1_q;
  assign rValid_o = (READ_LATENCY == 2) ? vld2_q : vld1_q;
  assign busy_o   = (state_q == StClear);

endmodule
